// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset sequencer slice:
//   - seqState_e : sequencer states (DELAY, WAIT, RUN, HOLD, FAULT)
//   - STAGE_W    : width of the stage index reported on oSTAGE
//   - RETRY_W    : width of the retry counter reported on oRETRY
//   - delayFits / paramsValid : elaboration-time parameter range checks
// No ports (package).
// ---------------------------------------------------------------------------
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_DELAY = 3'd0,
    ST_WAIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } seqState_e;

  localparam int STAGE_W = 3;
  localparam int RETRY_W = 2;

  // A delay of v cycles is matched at count v-1, so v-1 must be
  // representable in w bits and v must be at least one.
  function automatic bit delayFits(int v, int w);
    return (v >= 1) && (longint'(v) <= (longint'(1) << w));
  endfunction

  function automatic bit paramsValid(int nStages, int cntW, int stageDly,
                                     int tmo, int holdDly, int maxRetry);
    bit ok;
    ok = 1'b1;
    if (nStages < 1 || nStages > 8) ok = 1'b0;
    if (cntW < 1 || cntW > 31) ok = 1'b0;
    if (ok && !delayFits(stageDly, cntW)) ok = 1'b0;
    if (ok && !delayFits(tmo, cntW)) ok = 1'b0;
    if (ok && !delayFits(holdDly, cntW)) ok = 1'b0;
    if (maxRetry < 0 || maxRetry > 3) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// ---------------------------------------------------------------------------
// rst_seq_timer
// Clearable up-counter shared by the DELAY, WAIT and HOLD phases of the
// reset sequencer. Counts every cycle unless cleared; match_o flags that the
// current count equals the terminal value selected by the caller.
// Ports:
//   iCLK        in   system clock
//   iRST        in   asynchronous, active-low reset (count clears to 0)
//   clr_i       in   synchronous clear, takes priority over counting
//   matchVal_i  in   CNT_W terminal value compared against the count
//   match_o     out  high while count == matchVal_i
// ---------------------------------------------------------------------------
module rst_seq_timer #(
  parameter int CNT_W = 23
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] matchVal_i,
  output logic             match_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The owner clears on every terminal compare, so the count never wraps.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_o = (cnt_q == matchVal_i);

endmodule

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Common two-flop synchronizer cell for level signals crossing into iCLK.
// Ports:
//   iCLK  in   destination clock
//   iRST  in   asynchronous, active-low reset (both flops clear to 0)
//   d_i   in   WIDTH asynchronous level inputs
//   q_o   out  WIDTH synchronized outputs (2 cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Releases N_STAGES downstream reset domains strictly in order. Each release
// follows a settle delay, then the sequencer waits for that domain's ready
// acknowledge before moving on. Ack timeout, ack loss in RUN, or a soft-reset
// request drops every domain and re-sequences after a hold period; after
// MAX_RETRY fault restarts the sequencer parks in FAULT.
// Ports:
//   iCLK        in   system clock
//   iRST        in   asynchronous, active-low reset
//   iSOFT_RST   in   synchronous one-cycle request to re-sequence
//   iDONE       in   N_STAGES per-domain ready acks (asynchronous levels)
//   oRST        out  N_STAGES per-domain resets, active-low (1 = released)
//   oALL_READY  out  high only in RUN
//   oERR        out  sticky fault flag
//   oSTAGE      out  stage being sequenced (0 outside DELAY/WAIT)
//   oRETRY      out  fault restarts consumed
// ---------------------------------------------------------------------------
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES  = 4,
  parameter int CNT_W     = 23,
  parameter int STAGE_DLY = 2097151,
  parameter int TMO       = 4194303,
  parameter int HOLD_DLY  = 1048575,
  parameter int MAX_RETRY = 3
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSOFT_RST,
  input  logic [N_STAGES-1:0] iDONE,
  output logic [N_STAGES-1:0] oRST,
  output logic                oALL_READY,
  output logic                oERR,
  output logic [2:0]          oSTAGE,
  output logic [1:0]          oRETRY
);

  localparam bit PARAMS_OK = paramsValid(N_STAGES, CNT_W, STAGE_DLY, TMO,
                                         HOLD_DLY, MAX_RETRY);

  if (!PARAMS_OK) begin : gBadParams
    $error("reset_sequencer: parameter out of range or does not fit CNT_W");
  end

  localparam logic [CNT_W-1:0]   STAGE_MATCH = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0]   TMO_MATCH   = CNT_W'(TMO - 1);
  localparam logic [CNT_W-1:0]   HOLD_MATCH  = CNT_W'(HOLD_DLY - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(N_STAGES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  seqState_e             state_q, state_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic [N_STAGES-1:0]   rst_q, rst_d;
  logic                  err_q, err_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;

  logic [N_STAGES-1:0]   doneSync;
  logic                  doneCur;
  logic [N_STAGES-1:0]   relMask;
  logic                  timerClr;
  logic                  timerMatch;
  logic [CNT_W-1:0]      timerMatchVal;
  logic                  faultEvt;

  sync_2ff #(
    .WIDTH (N_STAGES)
  ) uDoneSync (
    .iCLK (iCLK),
    .iRST (iRST),
    .d_i  (iDONE),
    .q_o  (doneSync)
  );

  rst_seq_timer #(
    .CNT_W (CNT_W)
  ) uTimer (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .clr_i      (timerClr),
    .matchVal_i (timerMatchVal),
    .match_o    (timerMatch)
  );

  // Ack of the stage being sequenced, and the thermometer of domains that are
  // released once the current stage lets go. Building the release pattern as a
  // thermometer keeps the ordering invariant structural.
  always_comb begin
    doneCur = 1'b0;
    relMask = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (stage_q == STAGE_W'(i)) begin
        doneCur = doneSync[i];
      end
      relMask[i] = (STAGE_W'(i) <= stage_q);
    end
  end

  // The single timer serves three phases; pick the terminal count per state.
  always_comb begin
    case (state_q)
      ST_DELAY: timerMatchVal = STAGE_MATCH;
      ST_WAIT:  timerMatchVal = TMO_MATCH;
      ST_HOLD:  timerMatchVal = HOLD_MATCH;
      default:  timerMatchVal = '0;
    endcase
  end

  // Next-state logic. Priority, lowest to highest: per-state behaviour, then
  // the fault event (drops all domains), then the soft reset, which overrides
  // done, timeout and fault in the same cycle.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    rst_d    = rst_q;
    err_d    = err_q;
    retry_d  = retry_q;
    timerClr = 1'b0;
    faultEvt = 1'b0;

    case (state_q)
      ST_DELAY: begin
        if (timerMatch) begin
          rst_d    = relMask;
          state_d  = ST_WAIT;
          timerClr = 1'b1;
        end
      end
      ST_WAIT: begin
        if (doneCur) begin
          timerClr = 1'b1;
          if (stage_q == LAST_STAGE) begin
            state_d = ST_RUN;
            stage_d = '0;
          end else begin
            state_d = ST_DELAY;
            stage_d = stage_q + STAGE_W'(1);
          end
        end else if (timerMatch) begin
          faultEvt = 1'b1;
        end
      end
      ST_RUN: begin
        timerClr = 1'b1;
        if (!(&doneSync)) begin
          faultEvt = 1'b1;
        end
      end
      ST_HOLD: begin
        rst_d = '0;
        if (timerMatch) begin
          state_d  = ST_DELAY;
          stage_d  = '0;
          timerClr = 1'b1;
        end
      end
      ST_FAULT: begin
        rst_d    = '0;
        err_d    = 1'b1;
        timerClr = 1'b1;
      end
      default: begin
        state_d  = ST_DELAY;
        stage_d  = '0;
        rst_d    = '0;
        timerClr = 1'b1;
      end
    endcase

    if (faultEvt) begin
      rst_d    = '0;
      err_d    = 1'b1;
      stage_d  = '0;
      timerClr = 1'b1;
      if (retry_q < RETRY_LIMIT) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = ST_HOLD;
      end else begin
        state_d = ST_FAULT;
      end
    end

    if (iSOFT_RST) begin
      state_d  = ST_HOLD;
      stage_d  = '0;
      rst_d    = '0;
      err_d    = 1'b0;
      retry_d  = '0;
      timerClr = 1'b1;
    end
  end

  // State register; iRST returns everything to the power-up point at once.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= ST_DELAY;
      stage_q <= '0;
      rst_q   <= '0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      err_q   <= err_d;
      retry_q <= retry_d;
    end
  end

  assign oRST       = rst_q;
  assign oALL_READY = (state_q == ST_RUN);
  assign oERR       = err_q;
  assign oSTAGE     = ((state_q == ST_DELAY) || (state_q == ST_WAIT)) ? stage_q : '0;
  assign oRETRY     = retry_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Drives reset_sequencer with a reactive ack responder (random latencies,
// stuck acks, one-cycle ack drops, soft-reset pulses) and compares every
// output each cycle against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int N_STAGES  = 3;
  localparam int CNT_W     = 8;
  localparam int STAGE_DLY = 4;
  localparam int TMO       = 8;
  localparam int HOLD_DLY  = 5;
  localparam int MAX_RETRY = 2;

  localparam int P_DELAY = 0;
  localparam int P_WAIT  = 1;
  localparam int P_RUN   = 2;
  localparam int P_HOLD  = 3;
  localparam int P_FAULT = 4;

  logic                iCLK      = 1'b0;
  logic                iRST      = 1'b0;
  logic                iSOFT_RST = 1'b0;
  logic [N_STAGES-1:0] iDONE     = '0;
  logic [N_STAGES-1:0] oRST;
  logic                oALL_READY;
  logic                oERR;
  logic [2:0]          oSTAGE;
  logic [1:0]          oRETRY;

  int checkCount = 0;
  int passCount  = 0;

  // Responder state: each domain acks some cycles after its reset releases.
  logic [N_STAGES-1:0] respDone   = '0;
  int                  riseWait [N_STAGES];
  int                  maxLat     = 1;
  logic [N_STAGES-1:0] stuckMask  = '0;
  logic [N_STAGES-1:0] glitchMask = '0;
  logic [N_STAGES-1:0] forceMask  = '0;

  // Reference model: phase, number of domains released, cycles remaining in
  // the current timed phase, and a two-deep history of iDONE samples.
  int                  mPhase;
  int                  mStage;
  int                  mReleased;
  int                  mRemain;
  bit                  mErr;
  int                  mRetry;
  logic [N_STAGES-1:0] mHist [2];

  reset_sequencer #(
    .N_STAGES  (N_STAGES),
    .CNT_W     (CNT_W),
    .STAGE_DLY (STAGE_DLY),
    .TMO       (TMO),
    .HOLD_DLY  (HOLD_DLY),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iSOFT_RST  (iSOFT_RST),
    .iDONE      (iDONE),
    .oRST       (oRST),
    .oALL_READY (oALL_READY),
    .oERR       (oERR),
    .oSTAGE     (oSTAGE),
    .oRETRY     (oRETRY)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit isThermo(logic [N_STAGES-1:0] v);
    return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
  endfunction

  task modelReset();
    mPhase    = P_DELAY;
    mStage    = 0;
    mReleased = 0;
    mRemain   = STAGE_DLY;
    mErr      = 1'b0;
    mRetry    = 0;
    mHist[0]  = '0;
    mHist[1]  = '0;
  endtask

  task modelFault();
    mReleased = 0;
    mErr      = 1'b1;
    mStage    = 0;
    if (mRetry < MAX_RETRY) begin
      mRetry++;
      mPhase  = P_HOLD;
      mRemain = HOLD_DLY;
    end else begin
      mPhase = P_FAULT;
    end
  endtask

  task modelStep();
    logic [N_STAGES-1:0] seen;
    seen     = mHist[1];
    mHist[1] = mHist[0];
    mHist[0] = iDONE;
    if (iSOFT_RST) begin
      mPhase    = P_HOLD;
      mRemain   = HOLD_DLY;
      mReleased = 0;
      mStage    = 0;
      mErr      = 1'b0;
      mRetry    = 0;
    end else begin
      case (mPhase)
        P_DELAY: begin
          mRemain--;
          if (mRemain == 0) begin
            mReleased = mStage + 1;
            mPhase    = P_WAIT;
            mRemain   = TMO;
          end
        end
        P_WAIT: begin
          if (seen[mStage]) begin
            if (mStage == N_STAGES - 1) begin
              mPhase = P_RUN;
            end else begin
              mStage++;
              mPhase  = P_DELAY;
              mRemain = STAGE_DLY;
            end
          end else begin
            mRemain--;
            if (mRemain == 0) modelFault();
          end
        end
        P_RUN: begin
          if (seen != {N_STAGES{1'b1}}) modelFault();
        end
        P_HOLD: begin
          mRemain--;
          if (mRemain == 0) begin
            mPhase  = P_DELAY;
            mStage  = 0;
            mRemain = STAGE_DLY;
          end
        end
        default: ;
      endcase
    end
  endtask

  task compareAll();
    int expStage;
    expStage = ((mPhase == P_DELAY) || (mPhase == P_WAIT)) ? mStage : 0;
    checkOutput("rst",    32'(oRST),       32'((1 << mReleased) - 1));
    checkOutput("ready",  32'(oALL_READY), 32'(mPhase == P_RUN));
    checkOutput("err",    32'(oERR),       32'(mErr));
    checkOutput("stage",  32'(oSTAGE),     32'(expStage));
    checkOutput("retry",  32'(oRETRY),     32'(mRetry));
    checkOutput("thermo", 32'(isThermo(oRST)), 32'd1);
  endtask

  task respond();
    for (int k = 0; k < N_STAGES; k++) begin
      if (!oRST[k]) begin
        respDone[k] = 1'b0;
        riseWait[k] = int'($urandom_range(0, maxLat));
      end else if (!respDone[k]) begin
        if (riseWait[k] == 0) respDone[k] = 1'b1;
        else riseWait[k]--;
      end
    end
  endtask

  task applyStimulus();
    iDONE = (respDone & ~stuckMask & ~glitchMask) | forceMask;
  endtask

  task tick();
    @(posedge iCLK);
    if (iRST) modelStep();
    glitchMask = '0;
    @(negedge iCLK);
    compareAll();
    respond();
    applyStimulus();
  endtask

  task runUntilPhase(input int phase, input int stage, input int budget, input string tag);
    int n;
    n = 0;
    while (!(mPhase == phase && (stage < 0 || mStage == stage)) && n < budget) begin
      tick();
      n++;
    end
    checkOutput({"reach_", tag}, 32'(n < budget), 32'd1);
  endtask

  task softPulse();
    iSOFT_RST = 1'b1;
    tick();
    iSOFT_RST = 1'b0;
  endtask

  initial begin
    int n;
    for (int k = 0; k < N_STAGES; k++) riseWait[k] = 0;
    modelReset();
    applyStimulus();

    // Held in reset: everything low.
    tick();
    tick();
    checkOutput("reset_rst",   32'(oRST),       32'd0);
    checkOutput("reset_ready", 32'(oALL_READY), 32'd0);
    checkOutput("reset_retry", 32'(oRETRY),     32'd0);

    // Nominal bring-up: oRST[0] rises on the 4th edge after release.
    iRST = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("rst0_edge3", 32'(oRST[0]), 32'd0);
    tick();
    checkOutput("rst0_edge4", 32'(oRST[0]), 32'd1);
    runUntilPhase(P_RUN, -1, 200, "nominal_run");
    checkOutput("nom_ready", 32'(oALL_READY), 32'd1);
    checkOutput("nom_rst",   32'(oRST),       32'd7);
    checkOutput("nom_err",   32'(oERR),       32'd0);
    for (int i = 0; i < 5; i++) tick();

    // Loss of ack in RUN: a one-cycle drop on domain 2 faults two cycles later.
    glitchMask = 3'b100;
    applyStimulus();
    tick();
    tick();
    checkOutput("loss_still_ready", 32'(oALL_READY), 32'd1);
    tick();
    checkOutput("loss_rst",   32'(oRST),       32'd0);
    checkOutput("loss_ready", 32'(oALL_READY), 32'd0);
    checkOutput("loss_err",   32'(oERR),       32'd1);
    checkOutput("loss_retry", 32'(oRETRY),     32'd1);
    runUntilPhase(P_RUN, -1, 300, "loss_reseq");

    // Soft reset in WAIT(1) on the very edge the synchronized ack arrives.
    softPulse();
    stuckMask = 3'b010;
    runUntilPhase(P_WAIT, 1, 200, "wait1");
    forceMask = 3'b010;
    applyStimulus();
    tick();
    tick();
    iSOFT_RST = 1'b1;
    tick();
    iSOFT_RST = 1'b0;
    forceMask = '0;
    stuckMask = '0;
    applyStimulus();
    checkOutput("softwait_rst",   32'(oRST),   32'd0);
    checkOutput("softwait_stage", 32'(oSTAGE), 32'd0);
    checkOutput("softwait_err",   32'(oERR),   32'd0);
    checkOutput("softwait_retry", 32'(oRETRY), 32'd0);
    runUntilPhase(P_RUN, -1, 300, "softwait_run");

    // Timeout on domain 1.
    softPulse();
    stuckMask = 3'b010;
    applyStimulus();
    n = 0;
    while (mRetry == 0 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("reach_timeout", 32'(n < 200), 32'd1);
    checkOutput("tmo_rst",   32'(oRST),   32'd0);
    checkOutput("tmo_err",   32'(oERR),   32'd1);
    checkOutput("tmo_retry", 32'(oRETRY), 32'd1);
    stuckMask = '0;
    applyStimulus();
    runUntilPhase(P_RUN, -1, 300, "tmo_recover");

    // Retry exhaustion with domain 0 never acking.
    softPulse();
    stuckMask = 3'b001;
    applyStimulus();
    runUntilPhase(P_FAULT, -1, 400, "fault");
    for (int i = 0; i < 100; i++) tick();
    checkOutput("fault_rst",   32'(oRST),   32'd0);
    checkOutput("fault_err",   32'(oERR),   32'd1);
    checkOutput("fault_retry", 32'(oRETRY), 32'd2);

    // Soft reset leaves FAULT.
    stuckMask = '0;
    applyStimulus();
    softPulse();
    checkOutput("softfault_err",   32'(oERR),   32'd0);
    checkOutput("softfault_retry", 32'(oRETRY), 32'd0);
    runUntilPhase(P_RUN, -1, 300, "softfault_run");

    // Asynchronous reset mid WAIT(2), away from any clock edge.
    stuckMask = 3'b100;
    applyStimulus();
    runUntilPhase(P_WAIT, 2, 200, "wait2");
    #3;
    iRST = 1'b0;
    #1;
    checkOutput("async_rst",   32'(oRST),       32'd0);
    checkOutput("async_ready", 32'(oALL_READY), 32'd0);
    checkOutput("async_err",   32'(oERR),       32'd0);
    checkOutput("async_stage", 32'(oSTAGE),     32'd0);
    checkOutput("async_retry", 32'(oRETRY),     32'd0);
    modelReset();
    tick();
    tick();
    iRST = 1'b1;
    stuckMask = '0;
    applyStimulus();
    runUntilPhase(P_RUN, -1, 300, "async_recover");

    // Randomized soak: random latencies, stuck acks, ack drops, soft resets.
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) begin
        maxLat    = int'($urandom_range(0, 3));
        stuckMask = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end
      if ($urandom_range(0, 63) == 0) glitchMask = 3'(1 << $urandom_range(0, 2));
      iSOFT_RST = ($urandom_range(0, 299) == 0);
      applyStimulus();
      tick();
      iSOFT_RST = 1'b0;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
